// File: rtl/prim_fifo_sync_wm.sv
// Single-clock ready/valid FIFO with programmable watermarks, optional drop-on-full and sticky error.
// Define PRIM_FIFO_SYNC_WM_PARITY_EN to store an odd-parity bit per entry and check it on reads.
module prim_fifo_sync_wm #(
  parameter int unsigned Width             = 32,
  parameter int unsigned Depth             = 8,
  parameter bit          Pass              = 1'b1,
  parameter bit          DropOnFull        = 1'b0,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  input  logic [DepthW-1:0] af_th_i,
  input  logic [DepthW-1:0] ae_th_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [DepthW-1:0] depth_o,
  output logic [15:0]       drop_cnt_o,
  output logic              err_o
);

  localparam int unsigned IdxW = $clog2(Depth);
`ifdef PRIM_FIFO_SYNC_WM_PARITY_EN
  localparam int unsigned StoreW = Width + 1;
`else
  localparam int unsigned StoreW = Width;
`endif

  // Pointers are {wrap, index}; the index wraps at Depth-1, not at a power of two.
  logic [IdxW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic                under_rst_q;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                err_q, err_d;
  logic [StoreW-1:0]   mem_q [Depth];

  logic [IdxW-1:0]     widx, ridx;
  logic                same_wrap, full, empty, pass_thru;
  logic                wr_hs, rd_hs, wr_en, rd_en, drop;
  logic                ptr_bad, par_err;
  logic [DepthW-1:0]   depth;
  logic [StoreW-1:0]   wr_entry, rd_entry;
  int                  occ;

  function automatic logic [IdxW:0] ptr_inc(input logic [IdxW:0] p);
    if (p[IdxW-1:0] == IdxW'(Depth - 1)) begin
      return {~p[IdxW], {IdxW{1'b0}}};
    end
    return {p[IdxW], p[IdxW-1:0] + IdxW'(1)};
  endfunction

  assign widx      = wptr_q[IdxW-1:0];
  assign ridx      = rptr_q[IdxW-1:0];
  assign same_wrap = (wptr_q[IdxW] == rptr_q[IdxW]);
  assign empty     = (widx == ridx) && same_wrap;
  assign full      = (widx == ridx) && !same_wrap;

  always_comb begin
    depth = '0;
    if (full) begin
      depth = DepthW'(Depth);
    end else if (same_wrap) begin
      depth = DepthW'(widx) - DepthW'(ridx);
    end else begin
      depth = DepthW'(Depth) - DepthW'(ridx) + DepthW'(widx);
    end
  end

  // Occupancy in full-range arithmetic so a corrupted pointer pair cannot alias to a legal depth.
  always_comb begin
    occ = 0;
    if (same_wrap) begin
      occ = int'(widx) - int'(ridx);
    end else begin
      occ = int'(Depth) - int'(ridx) + int'(widx);
    end
  end
  assign ptr_bad = (occ > int'(Depth)) || (occ < 0);

  assign pass_thru = Pass && empty && wvalid_i && !under_rst_q;
  assign wready_o  = DropOnFull ? !under_rst_q : (!under_rst_q && !full);
  assign rvalid_o  = !under_rst_q && (!empty || pass_thru);

  assign wr_hs = wvalid_i && wready_o;
  assign rd_hs = rvalid_o && rready_i;
  assign drop  = wr_hs && full && !rd_hs;
  assign wr_en = wr_hs && !drop && !clr_i;
  assign rd_en = rd_hs && !clr_i;

  assign rd_entry = mem_q[ridx];

`ifdef PRIM_FIFO_SYNC_WM_PARITY_EN
  assign wr_entry = {~^wdata_i, wdata_i};
  assign par_err  = rd_hs && !pass_thru && !(^rd_entry);
`else
  assign wr_entry = wdata_i;
  assign par_err  = 1'b0;
`endif

  always_comb begin
    rdata_o = pass_thru ? wdata_i : rd_entry[Width-1:0];
    if (OutputZeroIfEmpty && !rvalid_o) begin
      rdata_o = '0;
    end
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    if (clr_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      drop_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (wr_en) wptr_d = ptr_inc(wptr_q);
      if (rd_en) rptr_d = ptr_inc(rptr_q);
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
      if (ptr_bad || par_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      drop_cnt_q  <= '0;
      err_q       <= 1'b0;
      under_rst_q <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_d;
      under_rst_q <= 1'b0;
    end
  end

  // Storage is deliberately not reset; rdata_o is masked by rvalid_o instead.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem_q[widx] <= wr_entry;
    end
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign depth_o        = depth;
  assign almost_full_o  = (depth >= af_th_i);
  assign almost_empty_o = (depth <= ae_th_i);
  assign drop_cnt_o     = drop_cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Bench: two FIFO configurations driven in parallel, each checked every cycle against a
// list-based occupancy model; directed scenarios followed by randomized traffic.
module tb_prim_fifo_sync_wm;

  localparam int unsigned DepthA = 6;
  localparam int unsigned DepthB = 4;

  logic        clk = 1'b0;
  logic        rst_n, clr, wvalid, rready;
  logic [31:0] wdata;
  logic [2:0]  af_th, ae_th;

  logic        wready_a, rvalid_a, full_a, empty_a, af_a, ae_a, err_a;
  logic [31:0] rdata_a;
  logic [2:0]  depth_a;
  logic [15:0] dcnt_a;
  logic        wready_b, rvalid_b, full_b, empty_b, af_b, ae_b, err_b;
  logic [31:0] rdata_b;
  logic [2:0]  depth_b;
  logic [15:0] dcnt_b;

  always #5 clk = ~clk;

  prim_fifo_sync_wm #(
    .Width(32), .Depth(DepthA), .Pass(1'b0), .DropOnFull(1'b0), .OutputZeroIfEmpty(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .wvalid_i(wvalid), .wready_o(wready_a), .wdata_i(wdata),
    .rvalid_o(rvalid_a), .rready_i(rready), .rdata_o(rdata_a),
    .af_th_i(af_th), .ae_th_i(ae_th),
    .full_o(full_a), .empty_o(empty_a), .almost_full_o(af_a), .almost_empty_o(ae_a),
    .depth_o(depth_a), .drop_cnt_o(dcnt_a), .err_o(err_a)
  );

  prim_fifo_sync_wm #(
    .Width(32), .Depth(DepthB), .Pass(1'b1), .DropOnFull(1'b1), .OutputZeroIfEmpty(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .wvalid_i(wvalid), .wready_o(wready_b), .wdata_i(wdata),
    .rvalid_o(rvalid_b), .rready_i(rready), .rdata_o(rdata_b),
    .af_th_i(af_th), .ae_th_i(ae_th),
    .full_o(full_b), .empty_o(empty_b), .almost_full_o(af_b), .almost_empty_o(ae_b),
    .depth_o(depth_b), .drop_cnt_o(dcnt_b), .err_o(err_b)
  );

  logic        o_wready [2], o_rvalid [2], o_full [2], o_empty [2], o_af [2], o_ae [2], o_err [2];
  logic [31:0] o_rdata [2];
  logic [2:0]  o_depth [2];
  logic [15:0] o_dcnt [2];
  assign o_wready[0] = wready_a; assign o_wready[1] = wready_b;
  assign o_rvalid[0] = rvalid_a; assign o_rvalid[1] = rvalid_b;
  assign o_full[0]   = full_a;   assign o_full[1]   = full_b;
  assign o_empty[0]  = empty_a;  assign o_empty[1]  = empty_b;
  assign o_af[0]     = af_a;     assign o_af[1]     = af_b;
  assign o_ae[0]     = ae_a;     assign o_ae[1]     = ae_b;
  assign o_err[0]    = err_a;    assign o_err[1]    = err_b;
  assign o_rdata[0]  = rdata_a;  assign o_rdata[1]  = rdata_b;
  assign o_depth[0]  = depth_a;  assign o_depth[1]  = depth_b;
  assign o_dcnt[0]   = dcnt_a;   assign o_dcnt[1]   = dcnt_b;

  // Reference model: per configuration an ordered list of stored words (head at index 0).
  int unsigned md  [2] = '{DepthA, DepthB};
  bit          mp  [2] = '{1'b0, 1'b1};
  bit          mdr [2] = '{1'b0, 1'b1};
  logic [31:0] mdata [2][8];
  int          mcnt  [2] = '{0, 0};
  int          mdrop [2] = '{0, 0};
  bit          mur   [2] = '{1'b1, 1'b1};
  bit          merr  [2] = '{1'b0, 1'b0};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_wready(input int k);
    return !mur[k] && (mdr[k] || (mcnt[k] < int'(md[k])));
  endfunction

  function automatic bit exp_rvalid(input int k);
    return !mur[k] && ((mcnt[k] > 0) || (mp[k] && wvalid));
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string       s;
      logic [31:0] er;
      s  = (k == 0) ? "a" : "b";
      er = !exp_rvalid(k) ? 32'h0 : ((mcnt[k] > 0) ? mdata[k][0] : wdata);
      check_eq({s, ".wready"}, 32'(o_wready[k]), 32'(exp_wready(k)));
      check_eq({s, ".rvalid"}, 32'(o_rvalid[k]), 32'(exp_rvalid(k)));
      check_eq({s, ".rdata"},  o_rdata[k], er);
      check_eq({s, ".depth"},  32'(o_depth[k]), 32'(mcnt[k]));
      check_eq({s, ".full"},   32'(o_full[k]),  32'(mcnt[k] == int'(md[k])));
      check_eq({s, ".empty"},  32'(o_empty[k]), 32'(mcnt[k] == 0));
      check_eq({s, ".af"},     32'(o_af[k]),    32'(mcnt[k] >= int'(af_th)));
      check_eq({s, ".ae"},     32'(o_ae[k]),    32'(mcnt[k] <= int'(ae_th)));
      check_eq({s, ".dcnt"},   32'(o_dcnt[k]),  32'(mdrop[k]));
      check_eq({s, ".err"},    32'(o_err[k]),   32'(merr[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit wh, rh;
      int n;
      wh = wvalid && exp_wready(k);
      rh = rready && exp_rvalid(k);
      n  = mcnt[k];
      if (!rst_n) begin
        mcnt[k] = 0; mdrop[k] = 0; mur[k] = 1'b1; merr[k] = 1'b0;
      end else if (mur[k]) begin
        mur[k] = 1'b0;
      end else if (clr) begin
        mcnt[k] = 0; mdrop[k] = 0; merr[k] = 1'b0;
      end else begin
        if (rh && n > 0) begin
          for (int i = 0; i < 7; i++) mdata[k][i] = mdata[k][i+1];
          mcnt[k]--;
        end
        if (wh) begin
          if (n == int'(md[k]) && !rh) begin
            if (mdrop[k] < 65535) mdrop[k]++;
          end else if (!(n == 0 && rh)) begin
            mdata[k][mcnt[k]] = wdata;
            mcnt[k]++;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic put(input logic w, input logic [31:0] d, input logic r);
    wvalid = w; wdata = d; rready = r;
    cycle();
  endtask

  task automatic clear();
    clr = 1'b1; wvalid = 1'b0; rready = 1'b0;
    cycle();
    clr = 1'b0;
  endtask

  initial begin
    int wp, rp;
    rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0;
    af_th = 3'd0; ae_th = 3'd0;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // Reset release: first cycle after release still refuses writes.
    cycle(); cycle();
    rst_n = 1'b1; wvalid = 1'b1; wdata = 32'h1234_5678;
    #1 check_eq("rel_wready_low", 32'(wready_a), 32'd0);
    cycle();
    check_eq("rel_wready_high", 32'(wready_a), 32'd1);
    cycle();
    check_eq("rel_depth", 32'(depth_a), 32'd1);
    wvalid = 1'b0;

    // Fill, drain and wrap on the 6-deep non-pass FIFO.
    clear();
    af_th = 3'd5; ae_th = 3'd1;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 6; i++) put(1'b1, 32'h10 + 32'(i), 1'b0);
      check_eq("fill_full", 32'(full_a), 32'd1);
      check_eq("fill_af", 32'(af_a), 32'd1);
      for (int i = 0; i < 6; i++) begin
        wvalid = 1'b0; rready = 1'b1;
        #1 check_eq("drain_data", rdata_a, 32'h10 + 32'(i));
        cycle();
      end
      check_eq("drain_depth", 32'(depth_a), 32'd0);
    end

    // Pass-through on the Pass=1 FIFO.
    clear();
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; rready = 1'b1; wdata = 32'hA5;
      #1 check_eq("pass_rdata", rdata_b, 32'hA5);
      cycle();
      check_eq("pass_depth", 32'(depth_b), 32'd0);
    end

    // Drop-on-full on the 4-deep FIFO.
    clear();
    for (int i = 0; i < 4; i++) put(1'b1, 32'h20 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) put(1'b1, 32'h30 + 32'(i), 1'b0);
    check_eq("drop_cnt", 32'(dcnt_b), 32'd3);
    check_eq("drop_depth", 32'(depth_b), 32'd4);
    wvalid = 1'b1; rready = 1'b1; wdata = 32'h40;
    #1 check_eq("drop_head", rdata_b, 32'h20);
    cycle();
    check_eq("drop_cnt_rw", 32'(dcnt_b), 32'd3);
    check_eq("drop_depth_rw", 32'(depth_b), 32'd4);
    for (int i = 0; i < 4; i++) put(1'b0, 32'h0, 1'b1);

    // Flush wins over a simultaneous read and write.
    clear();
    for (int i = 0; i < 3; i++) put(1'b1, 32'h50 + 32'(i), 1'b0);
    clr = 1'b1; wvalid = 1'b1; rready = 1'b1; wdata = 32'h99;
    cycle();
    clr = 1'b0; wvalid = 1'b0; rready = 1'b0;
    check_eq("flush_depth", 32'(depth_a), 32'd0);
    check_eq("flush_empty", 32'(empty_a), 32'd1);
    check_eq("flush_dcnt", 32'(dcnt_b), 32'd0);
    check_eq("flush_err", 32'(err_a), 32'd0);
    cycle();

`ifdef PRIM_FIFO_SYNC_WM_PARITY_EN
    // Corrupt stored entry 2 and expect a sticky error once it is read.
    clear();
    for (int i = 0; i < 3; i++) put(1'b1, 32'h60 + 32'(i), 1'b0);
    dut_a.mem_q[2][0] = ~dut_a.mem_q[2][0];
    mdata[0][2][0] = ~mdata[0][2][0];
    for (int i = 0; i < 3; i++) put(1'b0, 32'h0, 1'b1);
    merr[0] = 1'b1;
    check_eq("par_err_set", 32'(err_a), 32'd1);
    put(1'b0, 32'h0, 1'b0);
    put(1'b0, 32'h0, 1'b0);
    check_eq("par_err_sticky", 32'(err_a), 32'd1);
    clear();
    check_eq("par_err_clr", 32'(err_a), 32'd0);
`endif

    // Randomized traffic with phased write/read pressure, occasional flush and reset.
    wp = 50; rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        wp = int'($urandom_range(100));
        rp = int'($urandom_range(100));
      end
      if (c % 50 == 0) begin
        af_th = 3'($urandom_range(7));
        ae_th = 3'($urandom_range(7));
      end
      rst_n  = ($urandom_range(299) != 0);
      clr    = ($urandom_range(127) == 0);
      wvalid = (int'($urandom_range(99)) < wp);
      rready = (int'($urandom_range(99)) < rp);
      wdata  = $urandom();
      cycle();
    end
    rst_n = 1'b1; clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
